// File: rtl/jtframe_vtgen.sv
// Video timing generator: pixel/line counters with registered blanking, sync and frame markers.
// Optional vertical interrupt logic is built when JTFRAME_VTGEN_VIRQ_EN is defined.
module jtframe_vtgen #(
    parameter int W          = 9,
    parameter int HCNT_START = 0,
    parameter int HCNT_END   = 383,
    parameter int HB_START   = 256,
    parameter int HB_END     = 0,
    parameter int HS_START   = 300,
    parameter int HS_END     = 332,
    parameter int VCNT_START = 0,
    parameter int VCNT_END   = 263,
    parameter int VB_START   = 240,
    parameter int VB_END     = 16,
    parameter int VS_START   = 248,
    parameter int VS_END     = 251,
    parameter int VIRQ_LINE  = 240
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pxl_cen,
    output logic [W-1:0] hcnt,
    output logic [W-1:0] vcnt,
    output logic         LHBL,
    output logic         LVBL,
    output logic         HS,
    output logic         VS,
    output logic         Hinit,
    output logic         Vinit,
    output logic         virq,
    input  logic         virq_ack
);

    localparam logic [W-1:0] H_START  = W'(HCNT_START);
    localparam logic [W-1:0] H_END    = W'(HCNT_END);
    localparam logic [W-1:0] HB_S     = W'(HB_START);
    localparam logic [W-1:0] HB_E     = W'(HB_END);
    localparam logic [W-1:0] HS_S     = W'(HS_START);
    localparam logic [W-1:0] HS_E     = W'(HS_END);
    localparam logic [W-1:0] V_START  = W'(VCNT_START);
    localparam logic [W-1:0] V_END    = W'(VCNT_END);
    localparam logic [W-1:0] VB_S     = W'(VB_START);
    localparam logic [W-1:0] VB_E     = W'(VB_END);
    localparam logic [W-1:0] VS_S     = W'(VS_START);
    localparam logic [W-1:0] VS_E     = W'(VS_END);

    // Half-open window [s, e); wraps through the counter end when e < s, empty when s == e.
    function automatic logic in_win(input logic [W-1:0] v, input logic [W-1:0] s,
                                    input logic [W-1:0] e);
        if (s == e)
            in_win = 1'b0;
        else if (s < e)
            in_win = (v >= s) && (v < e);
        else
            in_win = (v >= s) || (v < e);
    endfunction

    logic [W-1:0] hcnt_q, hcnt_d;
    logic [W-1:0] vcnt_q, vcnt_d;
    logic         lhbl_q, lhbl_d;
    logic         lvbl_q, lvbl_d;
    logic         hs_q,   hs_d;
    logic         vs_q,   vs_d;
    logic         hinit_q, hinit_d;
    logic         vinit_q, vinit_d;
    logic         hwrap;

    always_comb begin
        hwrap  = (hcnt_q == H_END);
        hcnt_d = hwrap ? H_START : hcnt_q + W'(1);
        vcnt_d = vcnt_q;
        if (hwrap)
            vcnt_d = (vcnt_q == V_END) ? V_START : vcnt_q + W'(1);
    end

    // Flags decode the next counter values so they land on the same edge as the counters.
    always_comb begin
        lhbl_d  = ~in_win(hcnt_d, HB_S, HB_E);
        hs_d    =  in_win(hcnt_d, HS_S, HS_E);
        lvbl_d  = ~in_win(vcnt_d, VB_S, VB_E);
        vs_d    =  in_win(vcnt_d, VS_S, VS_E);
        hinit_d = (hcnt_d == H_START);
        vinit_d = (hcnt_d == H_START) && (vcnt_d == V_START);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q  <= H_START;
            vcnt_q  <= V_START;
            lhbl_q  <= 1'b0;
            lvbl_q  <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            hinit_q <= 1'b0;
            vinit_q <= 1'b0;
        end else if (pxl_cen) begin
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            lhbl_q  <= lhbl_d;
            lvbl_q  <= lvbl_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            hinit_q <= hinit_d;
            vinit_q <= vinit_d;
        end
    end

    assign hcnt  = hcnt_q;
    assign vcnt  = vcnt_q;
    assign LHBL  = lhbl_q;
    assign LVBL  = lvbl_q;
    assign HS    = hs_q;
    assign VS    = vs_q;
    assign Hinit = hinit_q;
    assign Vinit = vinit_q;

`ifdef JTFRAME_VTGEN_VIRQ_EN
    localparam logic [W-1:0] V_IRQ = W'(VIRQ_LINE);

    logic virq_q, virq_d;
    logic virq_set;

    // Set has priority over a coincident acknowledge; ack acts even while pxl_cen is low.
    always_comb begin
        virq_set = pxl_cen && (vcnt_d == V_IRQ) && (hcnt_d == H_START);
        virq_d   = virq_q;
        if (virq_set)
            virq_d = 1'b1;
        else if (virq_ack)
            virq_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            virq_q <= 1'b0;
        else
            virq_q <= virq_d;
    end

    assign virq = virq_q;
`else
    localparam int unused_virq_line = VIRQ_LINE;
    logic unused_virq_ack;
    assign unused_virq_ack = virq_ack;
    assign virq = 1'b0;
`endif

endmodule

// File: tb/tb_jtframe_vtgen.sv
// Scoreboard bench for jtframe_vtgen: default timing, a small wrapping-window timing and an empty HB window.
`timescale 1ns/1ps
module tb_jtframe_vtgen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pxl_cen = 1'b0;
    logic virq_ack = 1'b0;

    always #5 clk = ~clk;

    logic [8:0] d_hcnt, d_vcnt, s_hcnt, s_vcnt, n_hcnt, n_vcnt;
    logic d_LHBL, d_LVBL, d_HS, d_VS, d_Hinit, d_Vinit, d_virq;
    logic s_LHBL, s_LVBL, s_HS, s_VS, s_Hinit, s_Vinit, s_virq;
    logic n_LHBL, n_LVBL, n_HS, n_VS, n_Hinit, n_Vinit, n_virq;

    jtframe_vtgen u_def (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen),
        .hcnt(d_hcnt), .vcnt(d_vcnt), .LHBL(d_LHBL), .LVBL(d_LVBL),
        .HS(d_HS), .VS(d_VS), .Hinit(d_Hinit), .Vinit(d_Vinit),
        .virq(d_virq), .virq_ack(virq_ack)
    );

    // 12 pixels x 8 lines; both blanking windows wrap through the counter end.
    jtframe_vtgen #(
        .W(9), .HCNT_START(0), .HCNT_END(11), .HB_START(9), .HB_END(1),
        .HS_START(4), .HS_END(6), .VCNT_START(0), .VCNT_END(7),
        .VB_START(6), .VB_END(1), .VS_START(3), .VS_END(5), .VIRQ_LINE(5)
    ) u_sml (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen),
        .hcnt(s_hcnt), .vcnt(s_vcnt), .LHBL(s_LHBL), .LVBL(s_LVBL),
        .HS(s_HS), .VS(s_VS), .Hinit(s_Hinit), .Vinit(s_Vinit),
        .virq(s_virq), .virq_ack(virq_ack)
    );

    jtframe_vtgen #(.HB_START(10), .HB_END(10)) u_nob (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen),
        .hcnt(n_hcnt), .vcnt(n_vcnt), .LHBL(n_LHBL), .LVBL(n_LVBL),
        .HS(n_HS), .VS(n_VS), .Hinit(n_Hinit), .Vinit(n_Vinit),
        .virq(n_virq), .virq_ack(virq_ack)
    );

    typedef struct {
        int dh, dv;
        bit dlhbl, dlvbl, dhs, dvs, dhi, dvi;
        int sh, sv;
        bit slhbl, slvbl, shs, svs, shi, svi, svirq;
        bit nlhbl;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp, rst_e;
    int n_tests = 0;
    int n_fail = 0;
    int mdh, mdv, msh, msv;
    bit mvirq;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_tests++;
        if (act !== 32'(exp)) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input exp_t e);
        chk("def_hcnt", d_hcnt, e.dh);     chk("def_vcnt", d_vcnt, e.dv);
        chk("def_LHBL", d_LHBL, e.dlhbl);  chk("def_LVBL", d_LVBL, e.dlvbl);
        chk("def_HS", d_HS, e.dhs);        chk("def_VS", d_VS, e.dvs);
        chk("def_Hinit", d_Hinit, e.dhi);  chk("def_Vinit", d_Vinit, e.dvi);
        chk("def_virq", d_virq, 0);
        chk("sml_hcnt", s_hcnt, e.sh);     chk("sml_vcnt", s_vcnt, e.sv);
        chk("sml_LHBL", s_LHBL, e.slhbl);  chk("sml_LVBL", s_LVBL, e.slvbl);
        chk("sml_HS", s_HS, e.shs);        chk("sml_VS", s_VS, e.svs);
        chk("sml_Hinit", s_Hinit, e.shi);  chk("sml_Vinit", s_Vinit, e.svi);
        chk("sml_virq", s_virq, e.svirq);
        chk("nob_hcnt", n_hcnt, e.dh);     chk("nob_LHBL", n_LHBL, e.nlhbl);
    endtask

    // Expected outputs written out directly from the hand-derived windows of each instance.
    function automatic exp_t calc();
        exp_t e;
        e.dh = mdh; e.dv = mdv;
        e.dlhbl = (mdh < 256);
        e.dhs   = (mdh >= 300) && (mdh < 332);
        e.dlvbl = (mdv >= 16) && (mdv < 240);
        e.dvs   = (mdv >= 248) && (mdv < 251);
        e.dhi   = (mdh == 0);
        e.dvi   = (mdh == 0) && (mdv == 0);
        e.sh = msh; e.sv = msv;
        e.slhbl = (msh >= 1) && (msh < 9);
        e.shs   = (msh >= 4) && (msh < 6);
        e.slvbl = (msv >= 1) && (msv < 6);
        e.svs   = (msv >= 3) && (msv < 5);
        e.shi   = (msh == 0);
        e.svi   = (msh == 0) && (msv == 0);
        e.svirq = mvirq;
        e.nlhbl = 1'b1;
        return e;
    endfunction

    task automatic model_reset();
        mdh = 0; mdv = 0; msh = 0; msv = 0; mvirq = 1'b0;
        last_exp = rst_e;
    endtask

    task automatic step(input bit ack);
        @(negedge clk);
        pxl_cen = 1'b1;
        virq_ack = ack;
        mdh = (mdh == 383) ? 0 : mdh + 1;
        if (mdh == 0) mdv = (mdv == 263) ? 0 : mdv + 1;
        msh = (msh == 11) ? 0 : msh + 1;
        if (msh == 0) msv = (msv == 7) ? 0 : msv + 1;
`ifdef JTFRAME_VTGEN_VIRQ_EN
        if (msv == 5 && msh == 0) mvirq = 1'b1;
        else if (ack) mvirq = 1'b0;
`endif
        last_exp = calc();
        sb.push_back(last_exp);
    endtask

    task automatic idle(input bit ack, input bit hold);
        @(negedge clk);
        if (hold) check_all(last_exp);
        pxl_cen = 1'b0;
        virq_ack = ack;
`ifdef JTFRAME_VTGEN_VIRQ_EN
        if (ack) mvirq = 1'b0;
`endif
        last_exp.svirq = mvirq;
    endtask

    task automatic guard_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: target state not reached within cycle budget", name);
    endtask

    // Monitor: one clk after every pxl_cen the DUT presents a new pixel state.
    always @(posedge clk) begin
        bit cen_seen;
        cen_seen = pxl_cen;
        #1;
        if (cen_seen) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: got empty queue expected pending entry at %0t", $time);
            end else begin
                check_all(sb.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        rst_e = '{default: 0};
        model_reset();
        repeat (3) @(negedge clk);
        check_all(rst_e);
        rst_n = 1'b1;
        idle(0, 1);
        idle(0, 1);

        // Two default lines / eight small frames with pxl_cen on every second clk.
        for (int i = 0; i < 768; i++) begin
            step(0);
            idle(0, 0);
        end
        idle(1, 0);
        idle(0, 1);

        // Interrupt raise, hold for 10 clks, then acknowledge.
        g = 0;
        while (!(msv == 5 && msh == 0) && g < 200) begin step(0); g++; end
        if (g >= 200) guard_fail("virq_reach");
        repeat (10) idle(0, 1);
        idle(1, 1);
        idle(0, 1);
        idle(0, 1);

        // Acknowledge coinciding with the setting cen must leave virq high.
        g = 0;
        while (!(msv == 4 && msh == 11) && g < 200) begin step(0); g++; end
        if (g >= 200) guard_fail("virq_pre");
        step(1);
        idle(0, 1);
        idle(0, 1);
        idle(1, 0);
        idle(0, 1);

        // Freeze with pxl_cen low at hcnt=100, then the next cen gives 101.
        g = 0;
        while (mdh != 100 && g < 500) begin step(0); g++; end
        if (g >= 500) guard_fail("hold_reach");
        repeat (50) idle(0, 1);
        step(0);
        step(0);

        // Asynchronous mid-frame reset at hcnt=200.
        g = 0;
        while (!(mdh == 200 && mdv != 0) && g < 2000) begin step(0); g++; end
        if (g >= 2000) guard_fail("reset_reach");
        @(negedge clk);
        pxl_cen = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all(rst_e);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle(0, 1);
        idle(0, 1);
        repeat (400) step(0);
        idle(0, 0);

        repeat (4) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
